// File: rtl/jk_sched_pkg.sv
// Shared types for the JK flip-flop op scheduler: op encoding, FSM states and
// the reference next-state function used by the optional scoreboard.
package jk_sched_pkg;

  // J = op[1], K = op[0]
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StResp
  } sched_state_e;

  function automatic logic jk_next_q(input jk_op_e op, input logic q);
    logic nq;
    nq = q;
    unique case (op)
      HOLD:    nq = q;
      RESET:   nq = 1'b0;
      SET:     nq = 1'b1;
      TOGGLE:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching cyclically. The pointer itself lives in the caller.
module jk_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (en && !any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_op_scheduler.sv
// Time-shares one JK flip-flop between NUM_REQ requesters (IDLE->DRIVE->SAMPLE->RESP).
// Define JK_SCBD_EN to enable the Q/Qn reference-model scoreboard.
module jk_op_scheduler
  import jk_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = $clog2(NUM_REQ),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           rsp_op,
  output logic                 rsp_q,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy,
  output logic                 jk_j,
  output logic                 jk_k,
  output logic                 jk_reset,
  input  logic                 jk_q,
  input  logic                 jk_qn
);

  sched_state_e    state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            arb_en;
  logic [1:0]      op_sel;

  // No grants while the flop itself is still held in reset.
  assign arb_en = (state_q == StIdle) && !jk_reset;

  jk_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .en       (arb_en),
    .grant    (req_ready),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign op_sel = req_op[{grant_id, 1'b0} +: 2];
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      jk_j      <= 1'b0;
      jk_k      <= 1'b0;
      jk_reset  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_op    <= '0;
      rsp_q     <= 1'b0;
    end else begin
      jk_reset <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            rsp_id   <= grant_id;
            rsp_op   <= op_sel;
            jk_j     <= op_sel[1];
            jk_k     <= op_sel[0];
            rr_ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          // Flop captures J/K at the edge closing this cycle.
          jk_j    <= 1'b0;
          jk_k    <= 1'b0;
          state_q <= StSample;
        end
        StSample: begin
          rsp_q     <= jk_q;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef JK_SCBD_EN
  logic model_q;
  logic sample_err;

  // model_q already holds the post-op value by the time SAMPLE runs.
  assign sample_err = (jk_q != model_q) | (jk_qn != ~jk_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      model_q <= 1'b0;
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (state_q == StDrive) begin
        model_q <= jk_next_q(jk_op_e'(rsp_op), model_q);
      end
      if (state_q == StSample) begin
        rsp_err <= sample_err;
        if (sample_err && (err_cnt != '1)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_qn;
  assign unused_qn = jk_qn;
  assign rsp_err   = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_jk_op_scheduler.sv
// Directed bench for jk_op_scheduler with a behavioural JK flop on the jk_* pins.
// Scoreboard expectations follow JK_SCBD_EN when the bench is built with it.
module tb_jk_op_scheduler;

`ifdef JK_SCBD_EN
  localparam bit SCBD = 1'b1;
`else
  localparam bit SCBD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [1:0] rsp_op;
  logic       rsp_q;
  logic       rsp_err;
  logic [7:0] err_cnt;
  logic       busy;
  logic       jk_j;
  logic       jk_k;
  logic       jk_reset;
  logic       jk_q;
  logic       jk_qn;

  logic       flop_q;
  logic       qn_bad;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // Behavioural JK flop; qn_bad corrupts Qn to exercise the scoreboard.
  always @(posedge clk) begin
    if (jk_reset) flop_q <= 1'b0;
    else begin
      case ({jk_j, jk_k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end
  assign jk_q  = flop_q;
  assign jk_qn = qn_bad ? flop_q : ~flop_q;

  jk_op_scheduler #(
    .NUM_REQ   (4),
    .ID_W      (2),
    .ERR_CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_q     (rsp_q),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_reset  (jk_reset),
    .jk_q      (jk_q),
    .jk_qn     (jk_qn)
  );

  // Issue one op and return at the first cycle showing rsp_valid (state RESP).
  task automatic run_op(input int id, input logic [1:0] op, output logic ok);
    req_valid[id] = 1'b1;
    req_op[2*id +: 2] = op;
    #1;
    ok = 1'b0;
    for (int c = 0; c < 16 && !req_ready[id]; c++) begin
      @(posedge clk); #1;
    end
    if (req_ready[id]) begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      for (int c = 0; c < 8 && !rsp_valid; c++) begin
        @(posedge clk); #1;
      end
      ok = rsp_valid;
    end
    req_valid[id] = 1'b0;
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL op_handshake: id %0d got no response", id);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (jk_reset !== 1'b1) begin n_err++; $display("FAIL rst_jk_reset: got %b exp 1", jk_reset); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt: got %0d exp 0", err_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    reset = 1'b0;
    req_valid = 4'hf;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_gap_ready: got %b exp 0000", req_ready); end
    n_vec++; if (jk_reset !== 1'b1) begin n_err++; $display("FAIL rst_gap_jk_reset: got %b exp 1", jk_reset); end
    req_valid = 4'h0;
    @(posedge clk); #1;
    n_vec++; if (jk_reset !== 1'b0) begin n_err++; $display("FAIL rst_release: got %b exp 0", jk_reset); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_op[1:0] = 2'b10;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_vec++; if ({busy, jk_j, jk_k, rsp_valid} !== 4'b1100) begin
      n_err++; $display("FAIL single_drive: busy/j/k/vld got %b exp 1100", {busy, jk_j, jk_k, rsp_valid});
    end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_busy: got %b exp 0000", req_ready); end
    @(posedge clk); #1;
    n_vec++; if ({busy, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL single_sample: busy/vld got %b exp 10", {busy, rsp_valid}); end
    @(posedge clk); #1;
    n_vec++; if ({rsp_valid, rsp_id, rsp_op, rsp_q, rsp_err, busy} !== 8'b1_00_10_1_0_1) begin
      n_err++; $display("FAIL single_resp: got %b exp 10010101", {rsp_valid, rsp_id, rsp_op, rsp_q, rsp_err, busy});
    end
    @(posedge clk); #1;
    n_vec++; if ({busy, rsp_valid} !== 2'b00) begin n_err++; $display("FAIL single_idle: busy/vld got %b exp 00", {busy, rsp_valid}); end
  endtask

  task automatic test_op_sequence();
    logic [1:0] ops [5];
    logic       exp_q [5];
    logic       ok;
    ops   = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(2, ops[i], ok);
      n_vec++; if ({rsp_id, rsp_op, rsp_q, rsp_err} !== {2'd2, ops[i], exp_q[i], 1'b0}) begin
        n_err++; $display("FAIL seq_%0d: id/op/q/err got %b exp %b", i,
                          {rsp_id, rsp_op, rsp_q, rsp_err}, {2'd2, ops[i], exp_q[i], 1'b0});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    logic [1:0] exp_id;
    run_op(3, 2'b00, ok);  // moves rr_ptr back to 0
    @(posedge clk); #1;
    req_op = 8'b11_10_01_00;
    req_valid = 4'hf;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_id = 2'(i % 4);
      n_vec++; if (req_ready !== (4'b0001 << exp_id)) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b exp %b", i, req_ready, 4'b0001 << exp_id);
      end
      repeat (3) begin @(posedge clk); #1; end
      n_vec++; if ({rsp_valid, rsp_id, rsp_op} !== {1'b1, exp_id, exp_id}) begin
        n_err++; $display("FAIL rr_resp_%0d: vld/id/op got %b exp %b", i, {rsp_valid, rsp_id, rsp_op}, {1'b1, exp_id, exp_id});
      end
      @(posedge clk); #1;
    end
    // rr_ptr is 1 now: req0 and req3 valid -> req3 wins
    req_valid = 4'b1001;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_wrap: got %b exp 1000", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic ok;
    rsp_ready = 1'b0;
    run_op(1, 2'b10, ok);
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++; if ({rsp_valid, rsp_id, rsp_op, rsp_q, busy, req_ready} !== 11'b1_01_10_1_1_0000) begin
        n_err++; $display("FAIL bp_hold_%0d: got %b exp 10110110000", i,
                          {rsp_valid, rsp_id, rsp_op, rsp_q, busy, req_ready});
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({rsp_valid, req_ready} !== 5'b0_0001) begin
      n_err++; $display("FAIL bp_resume: vld/ready got %b exp 00001", {rsp_valid, req_ready});
    end
    req_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_scoreboard();
    logic ok;
    qn_bad = 1'b1;
    run_op(0, 2'b10, ok);
    n_vec++; if ({rsp_q, rsp_err} !== {1'b1, SCBD}) begin
      n_err++; $display("FAIL scbd_err: q/err got %b exp %b", {rsp_q, rsp_err}, {1'b1, SCBD});
    end
    n_vec++; if (err_cnt !== {7'd0, SCBD}) begin
      n_err++; $display("FAIL scbd_cnt: got %0d exp %0d", err_cnt, SCBD);
    end
    qn_bad = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_drive();
    req_valid = 4'b0010;
    req_op[3:2] = 2'b10;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rid_grant: got %b exp 0010", req_ready); end
    @(posedge clk); #1;
    n_vec++; if ({busy, jk_j} !== 2'b11) begin n_err++; $display("FAIL rid_drive: busy/j got %b exp 11", {busy, jk_j}); end
    reset = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    n_vec++; if ({busy, rsp_valid, jk_reset, jk_j, rsp_id, rsp_op} !== 8'b0010_0000) begin
      n_err++; $display("FAIL rid_abort: busy/vld/jkrst/j/id/op got %b exp 00100000",
                        {busy, rsp_valid, jk_reset, jk_j, rsp_id, rsp_op});
    end
    n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rid_err_cnt: got %0d exp 0", err_cnt); end
    reset = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'hf;
    #1;
    n_vec++; if ({jk_reset, req_ready} !== 5'b0_0001) begin
      n_err++; $display("FAIL rid_ptr_reset: jkrst/ready got %b exp 00001", {jk_reset, req_ready});
    end
    req_valid = 4'h0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'h0;
    req_op    = 8'h00;
    rsp_ready = 1'b1;
    qn_bad    = 1'b0;
    test_reset();
    test_single();
    test_op_sequence();
    test_round_robin();
    test_backpressure();
    test_scoreboard();
    test_reset_in_drive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
